// File: rtl/result_register_file.sv
// result_register_file
//
// Purpose: bank of NUM_REGS result registers written by the compute pipeline
// and read by the host/readout side. One synchronous write port, one
// combinational read port, and a synchronous bulk clear that takes priority
// over writes. An asynchronous active-low reset zeroes the whole bank.
//
// Optional feature macro: RESULT_REGISTERS_BYPASS_EN
//   defined   - write-through forwarding: while a write targets the address
//               being read (and no clear is pending), out_data shows in_data
//               in the same cycle.
//   undefined - out_data always shows the stored register value.
//
// Ports:
//   clk        in   1           rising-edge clock
//   n_rst      in   1           asynchronous active-low reset
//   out_sel    in   SEL_WIDTH   read address
//   in_sel     in   SEL_WIDTH   write address
//   w_enable   in   1           write strobe, active high
//   clear_data in   1           synchronous clear of all registers, active high
//   in_data    in   DATA_WIDTH  write data
//   out_data   out  DATA_WIDTH  contents of regs[out_sel] (combinational)

module result_register_file #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_REGS   = 16,
    parameter int unsigned SEL_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic [SEL_WIDTH-1:0]  out_sel,
    input  logic [SEL_WIDTH-1:0]  in_sel,
    input  logic                  w_enable,
    input  logic                  clear_data,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic [DATA_WIDTH-1:0] out_data
);

    // Every selector value must address a real register (no range checking).
    generate
        if (NUM_REGS != (1 << SEL_WIDTH)) begin : g_bad_cfg
            $error("result_register_file: NUM_REGS must equal 2**SEL_WIDTH");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    // Register bank: reset and clear zero everything; clear beats write.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs[i] <= '0;
            end
        end else if (clear_data) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs[i] <= '0;
            end
        end else if (w_enable) begin
            regs[in_sel] <= in_data;
        end
    end

    // Read port, with optional same-cycle forwarding of a matching write.
`ifdef RESULT_REGISTERS_BYPASS_EN
    logic fwd_hit_c;

    always_comb begin
        fwd_hit_c = w_enable && !clear_data && (in_sel == out_sel);
        out_data  = regs[out_sel];
        if (fwd_hit_c) begin
            out_data = in_data;
        end
    end
`else
    always_comb begin
        out_data = regs[out_sel];
    end
`endif

endmodule

// File: tb/tb_result_register_file.sv
// Self-checking bench for result_register_file. Expected values come from a
// bench-side model of the bank and are queued when stimulus is driven, then
// popped and compared when out_data is sampled.

module tb_result_register_file;

    localparam int unsigned DW = 16;
    localparam int unsigned NR = 16;
    localparam int unsigned SW = 4;

    logic          clk;
    logic          n_rst;
    logic [SW-1:0] out_sel;
    logic [SW-1:0] in_sel;
    logic          w_enable;
    logic          clear_data;
    logic [DW-1:0] in_data;
    logic [DW-1:0] out_data;

    logic [DW-1:0] model [NR];
    logic [DW-1:0] exp_q [$];
    int            n_cmp;
    int            n_err;

    result_register_file #(
        .DATA_WIDTH (DW),
        .NUM_REGS   (NR),
        .SEL_WIDTH  (SW)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .out_sel    (out_sel),
        .in_sel     (in_sel),
        .w_enable   (w_enable),
        .clear_data (clear_data),
        .in_data    (in_data),
        .out_data   (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic compare(input string tag);
        logic [DW-1:0] exp;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $error("FAIL %s: observed empty scoreboard expected queued value", tag);
        end else begin
            exp = exp_q.pop_front();
            assert (out_data === exp) else begin
                n_err++;
                $error("FAIL %s: observed %h expected %h", tag, out_data, exp);
            end
        end
    endtask

    // Drive a read address, queue its model value, sample 1 time unit later.
    task automatic read_check(input int addr, input string tag);
        exp_q.push_back(model[addr]);
        out_sel = SW'(addr);
        #1;
        compare($sformatf("%s[%0d]", tag, addr));
    endtask

    task automatic sweep_check(input string tag);
        for (int i = 0; i < int'(NR); i++) begin
            read_check(i, tag);
        end
    endtask

    task automatic model_zero();
        for (int i = 0; i < int'(NR); i++) begin
            model[i] = '0;
        end
    endtask

    // One write through a single clock edge, then idle.
    task automatic do_write(input int addr, input logic [DW-1:0] data);
        @(negedge clk);
        in_sel   = SW'(addr);
        in_data  = data;
        w_enable = 1'b1;
        @(negedge clk);
        w_enable = 1'b0;
        model[addr] = data;
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        n_rst      = 1'b0;
        out_sel    = '0;
        in_sel     = '0;
        w_enable   = 1'b0;
        clear_data = 1'b0;
        in_data    = '0;
        model_zero();

        // Reset held for two cycles, then released; whole bank reads zero.
        @(posedge clk);
        @(posedge clk);
        read_check(0, "in_reset");
        @(negedge clk);
        n_rst = 1'b1;
        sweep_check("reset_sweep");

        // Write sweep, one write per cycle, then read everything back.
        for (int i = 0; i < int'(NR); i++) begin
            @(negedge clk);
            in_sel   = SW'(i);
            in_data  = 16'h1000 + DW'(i);
            w_enable = 1'b1;
            model[i] = 16'h1000 + DW'(i);
        end
        @(negedge clk);
        w_enable = 1'b0;
        sweep_check("write_sweep");

        // Hold: stray data on the write port with the strobe low.
        in_data = 16'hFFFF;
        in_sel  = 4'd3;
        repeat (5) @(negedge clk);
        read_check(3, "hold");
        read_check(4, "hold_neighbour");

        // Clear together with a write to address 7; clear wins.
        @(negedge clk);
        clear_data = 1'b1;
        w_enable   = 1'b1;
        in_sel     = 4'd7;
        in_data    = 16'hBEEF;
        read_check(7, "clear_pending_no_fwd");
        @(negedge clk);
        clear_data = 1'b0;
        w_enable   = 1'b0;
        model_zero();
        sweep_check("clear_sweep");

        // Writes still land after a clear; back-to-back same address, last wins.
        do_write(2, 16'h4242);
        read_check(2, "post_clear_write");
        @(negedge clk);
        in_sel   = 4'd4;
        in_data  = 16'h1111;
        w_enable = 1'b1;
        @(negedge clk);
        in_data  = 16'h2222;
        @(negedge clk);
        w_enable = 1'b0;
        model[4] = 16'h2222;
        read_check(4, "back_to_back");
        read_check(2, "back_to_back_other");

        // Async reset between edges, with a write pending, zeroes the bank.
        do_write(9, 16'hA5A5);
        read_check(9, "pre_async_reset");
        @(negedge clk);
        in_sel   = 4'd9;
        in_data  = 16'h5A5A;
        w_enable = 1'b1;
        #1;
        n_rst = 1'b0;
        model_zero();
        read_check(9, "async_reset");

        // First edge after release performs a write.
        @(negedge clk);
        in_sel   = 4'd1;
        in_data  = 16'h7777;
        w_enable = 1'b1;
        n_rst    = 1'b1;
        @(negedge clk);
        w_enable = 1'b0;
        model[1] = 16'h7777;
        read_check(1, "first_edge_write");
        read_check(9, "first_edge_other");

        // Read-during-write on the same address, with and without forwarding.
        do_write(5, 16'h1234);
        @(negedge clk);
        out_sel  = 4'd5;
        in_sel   = 4'd5;
        in_data  = 16'h5678;
        w_enable = 1'b1;
`ifdef RESULT_REGISTERS_BYPASS_EN
        exp_q.push_back(16'h5678);
`else
        exp_q.push_back(16'h1234);
`endif
        #1;
        compare("bypass_before_edge");
        @(posedge clk);
        #1;
        model[5] = 16'h5678;
        exp_q.push_back(model[5]);
        compare("bypass_after_edge");

        // A write to a different address never forwards.
        @(negedge clk);
        in_sel  = 4'd6;
        in_data = 16'h9999;
        read_check(5, "no_fwd_other_addr");
        @(negedge clk);
        w_enable = 1'b0;
        model[6] = 16'h9999;
        read_check(6, "other_addr_written");

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
